// File: rtl/hdlc_outputregister.sv
// HDLC 16-bit serializing transmitter: flag-delimited frames, LSB-first data,
// zero-bit insertion after five ones, abort (eight ones) on source underrun.
module hdlc_outputregister (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic        frame_end,
  output logic        data_taken,
  output logic        data_out,
  output logic        frame_active,
  output logic        underrun
);

  // state | meaning
  // IDLE  | continuous flags; a word may be captured on flag bit 7
  // DATA  | serializing sh with zero-bit insertion
  // EOF   | closing flag
  // ABORT | eight ones after an underrun
  typedef enum logic [1:0] {IDLE, DATA, EOF, ABORT} state_t;

  localparam logic [7:0] FLAG = 8'b0111_1110;

  state_t      state, nxt_state;
  logic [3:0]  cnt, nxt_cnt;
  logic [15:0] sh, nxt_sh;
  logic [2:0]  ones, nxt_ones;
  logic        last, nxt_last;
  logic        nxt_out, nxt_taken, nxt_underrun;
  logic [2:0]  cnt_inc3;

  // cnt always indexes the bit currently on the line (data bit or flag bit)
  assign cnt_inc3     = cnt[2:0] + 3'd1;
  assign frame_active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sh         <= 16'd0;
      ones       <= 3'd0;
      last       <= 1'b0;
      data_out   <= 1'b0;
      data_taken <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      sh         <= nxt_sh;
      ones       <= nxt_ones;
      last       <= nxt_last;
      data_out   <= nxt_out;
      data_taken <= nxt_taken;
      underrun   <= nxt_underrun;
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_sh       = sh;
    nxt_ones     = ones;
    nxt_last     = last;
    nxt_out      = data_out;
    nxt_taken    = 1'b0;
    nxt_underrun = underrun;
    case (state)
      IDLE: begin
        if (cnt == 4'd7) begin
          nxt_cnt = 4'd0;
          if (data_valid) begin
            nxt_state = DATA;
            nxt_sh    = data_in;
            nxt_last  = frame_end;
            nxt_out   = data_in[0];
            nxt_ones  = {2'b00, data_in[0]};
            nxt_taken = 1'b1;
          end else begin
            nxt_out = FLAG[0];
          end
        end else begin
          nxt_cnt = cnt + 4'd1;
          nxt_out = FLAG[cnt_inc3];
        end
      end
      DATA: begin
        if (ones == 3'd5) begin
          // stuff bit: line gets a 0, shift register and bit counter hold
          nxt_out  = 1'b0;
          nxt_ones = 3'd0;
        end else if (cnt == 4'd15) begin
          nxt_cnt = 4'd0;
          if (last) begin
            nxt_state = EOF;
            nxt_out   = FLAG[0];
          end else if (data_valid) begin
            nxt_sh    = data_in;
            nxt_last  = frame_end;
            nxt_out   = data_in[0];
            nxt_ones  = data_in[0] ? ones + 3'd1 : 3'd0;
            nxt_taken = 1'b1;
          end else begin
            nxt_state    = ABORT;
            nxt_out      = 1'b1;
            nxt_underrun = 1'b1;
          end
        end else begin
          nxt_cnt  = cnt + 4'd1;
          nxt_sh   = sh >> 1;
          nxt_out  = sh[1];
          nxt_ones = sh[1] ? ones + 3'd1 : 3'd0;
        end
      end
      EOF: begin
        if (cnt == 4'd7) begin
          nxt_state = IDLE;
          nxt_cnt   = 4'd0;
          nxt_out   = FLAG[0];
        end else begin
          nxt_cnt = cnt + 4'd1;
          nxt_out = FLAG[cnt_inc3];
        end
      end
      ABORT: begin
        if (cnt == 4'd7) begin
          nxt_state = IDLE;
          nxt_cnt   = 4'd0;
          nxt_out   = FLAG[0];
        end else begin
          nxt_cnt = cnt + 4'd1;
          nxt_out = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = 4'd0;
        nxt_out   = FLAG[0];
      end
    endcase
  end

endmodule

// File: tb/tb_hdlc_outputregister.sv
// Bench for hdlc_outputregister: expected line bitstream is built from the
// framing rules (bit list + stuffing + flag/abort) and compared cycle by cycle.
module tb_hdlc_outputregister;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        frame_end;
  logic        data_taken;
  logic        data_out;
  logic        frame_active;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  bit exp_underrun = 1'b0;

  localparam logic [7:0] FLAG = 8'h7E;

  logic [15:0] words [4];
  int          nwords;
  bit          fe_last;
  bit          exp_q[$];
  bit          tk_q[$];

  hdlc_outputregister dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .frame_end(frame_end), .data_taken(data_taken), .data_out(data_out),
    .frame_active(frame_active), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference: line bits of a whole frame from the first data bit onward.
  task automatic build_stream();
    int o;
    bit b;
    o = 0;
    exp_q.delete();
    tk_q.delete();
    for (int k = 0; k < nwords; k++) begin
      for (int i = 0; i < 16; i++) begin
        b = words[k][i];
        exp_q.push_back(b);
        tk_q.push_back(i == 0);
        o = b ? o + 1 : 0;
        if (o == 5) begin
          exp_q.push_back(1'b0);
          tk_q.push_back(1'b0);
          o = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(fe_last ? FLAG[i] : 1'b1);
      tk_q.push_back(1'b0);
    end
  endtask

  task automatic check_idle(input string name, input int n, input int start);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      checks++;
      if ({data_out, frame_active, data_taken} !== {FLAG[(start + j) % 8], 2'b00}) begin
        errors++;
        $display("FAIL %s idle[%0d]: out/active/taken=%b%b%b required %b00",
                 name, j, data_out, frame_active, data_taken, FLAG[(start + j) % 8]);
      end
    end
    checks++;
    if (underrun !== exp_underrun) begin
      errors++;
      $display("FAIL %s underrun: got %b required %b", name, underrun, exp_underrun);
    end
  endtask

  task automatic send_frame(input string name);
    int  k, lat;
    bit  seen;
    build_stream();
    data_in    = words[0];
    frame_end  = (nwords == 1) && fe_last;
    data_valid = 1'b1;
    k = 0; lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (data_taken === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || lat > 8) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (taken seen=%0b) required <=8", name, lat, seen);
      if (!seen) begin
        data_valid = 1'b0;
        return;
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({data_out, data_taken, frame_active} !== {exp_q[i], tk_q[i], 1'b1}) begin
        errors++;
        $display("FAIL %s bit[%0d]: out/taken/active=%b%b%b required %b%b1",
                 name, i, data_out, data_taken, frame_active, exp_q[i], tk_q[i]);
      end
      if (tk_q[i]) begin
        k++;
        if (k < nwords) begin
          data_in   = words[k];
          frame_end = (k == nwords - 1) && fe_last;
        end else begin
          data_valid = 1'b0;
          frame_end  = 1'b0;
          data_in    = 16'($urandom);
        end
      end
    end
    if (!fe_last) exp_underrun = 1'b1;
    check_idle(name, 8, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_out, data_taken, frame_active, underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset state: out/taken/active/underrun=%b%b%b%b required 0000",
               data_out, data_taken, frame_active, underrun);
    end
    reset = 1'b0;
    exp_underrun = 1'b0;
    check_idle("reset_idle", 32, 1);
  endtask

  task automatic test_single_a5c3();
    words[0] = 16'hA5C3; nwords = 1; fe_last = 1'b1;
    send_frame("single_a5c3");
  endtask

  task automatic test_ffff();
    words[0] = 16'hFFFF; nwords = 1; fe_last = 1'b1;
    send_frame("single_ffff");
    checks++;
    if (exp_q.size() - 8 != 19) begin
      errors++;
      $display("FAIL ffff_length: got %0d data cycles required 19", exp_q.size() - 8);
    end
  endtask

  task automatic test_back_to_back();
    words[0] = 16'h001F; words[1] = 16'hFFF8; nwords = 2; fe_last = 1'b1;
    send_frame("back_to_back");
  endtask

  task automatic test_abort();
    words[0] = 16'h1234; nwords = 1; fe_last = 1'b0;
    send_frame("abort_1234");
    words[0] = 16'h00FF; words[1] = 16'h8001; nwords = 2; fe_last = 1'b1;
    send_frame("underrun_sticky");
  endtask

  task automatic test_mid_frame_reset();
    int lat;
    lat = 0;
    data_in = 16'h1234; frame_end = 1'b1; data_valid = 1'b1;
    while (data_taken !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if ({data_out, frame_active} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midreset bit7: out/active=%b%b required 01", data_out, frame_active);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_out, data_taken, frame_active, underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset state: out/taken/active/underrun=%b%b%b%b required 0000",
               data_out, data_taken, frame_active, underrun);
    end
    reset = 1'b0;
    exp_underrun = 1'b0;
    check_idle("midreset_idle", 16, 1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      nwords = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++)
        words[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      fe_last = ($urandom_range(0, 3) != 0);
      send_frame($sformatf("random%0d", f));
      repeat ($urandom_range(0, 9)) begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset = 1'b1; data_in = 16'h0; data_valid = 1'b0; frame_end = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_a5c3();
    test_ffff();
    test_back_to_back();
    test_abort();
    test_mid_frame_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
